// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: one 32-bit read in flight at a time, results queued with their PCs.
// Flush redirects the fetch PC, empties the queue and discards any word still owed by memory.
module instr_prefetch #(
  parameter int          M_WIDTH    = 32,
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic [1:0]  MEM_ACC_32 = 2'b10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  input  logic                       flush,
  input  logic [M_WIDTH-1:0]         flush_pc,
  output logic                       mem_request,
  output logic [M_WIDTH-1:0]         mem_addr,
  output logic                       mem_we,
  output logic [1:0]                 mem_data_width,
  input  logic                       mem_ready,
  input  logic [M_WIDTH-1:0]         mem_data_in,
  output logic                       instr_valid,
  output logic [M_WIDTH-1:0]         instr_data,
  output logic [M_WIDTH-1:0]         instr_pc,
  input  logic                       instr_ready,
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [M_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [M_WIDTH-1:0] addr_q, addr_d;
  logic               discard_q, discard_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [M_WIDTH-1:0] data_q [DEPTH];
  logic [M_WIDTH-1:0] data_d [DEPTH];
  logic [M_WIDTH-1:0] pc_q   [DEPTH];
  logic [M_WIDTH-1:0] pc_d   [DEPTH];
  logic               push;
  logic               pop;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_d     = data_q;
    pc_d       = pc_q;
    push       = 1'b0;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Only one request is ever pending, so free space is judged on q_count alone here.
        if (fetch_en && !flush && (count_q < CW'(DEPTH))) begin
          state_d = S_REQ;
          addr_d  = fetch_pc_q;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          state_d   = S_GAP;
          discard_d = 1'b0;
          if (!discard_q && !flush) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + M_WIDTH'(4);
          end
        end else if (flush) begin
          discard_d = 1'b1;
        end
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pop = (count_q != '0) && instr_ready && !flush;

    if (push) begin
      data_d[wr_ptr_q] = mem_data_in;
      pc_d[wr_ptr_q]   = fetch_pc_q;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flush wins over everything queued this cycle.
    if (flush) begin
      fetch_pc_d = flush_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      discard_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
    pc_q   <= pc_d;
  end

  assign mem_request    = (state_q == S_REQ);
  assign mem_addr       = addr_q;
  assign mem_we         = 1'b0;
  assign mem_data_width = MEM_ACC_32;
  assign instr_valid    = (count_q != '0);
  assign instr_data     = data_q[rd_ptr_q];
  assign instr_pc       = pc_q[rd_ptr_q];
  assign q_count        = count_q;

endmodule
